keypad_scanner: RTL

//   Input-side counterpart of the multiplexed 7-seg display driver: scans a 4x4 matrix keypad.

---
 rtl/keypad_scanner.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one row at a time,
// debounces over whole scan frames and reports accepted presses as a
// 4-bit code {row, col} with a single-cycle KeyValid strobe.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       Clk100MHz,
    input  logic       Rst,
    input  logic [3:0] Col,
    output logic [3:0] Row,
    output logic [3:0] KeyCode,
    output logic       KeyValid,
    output logic       KeyHeld,
    output logic       MultiKey
);

    localparam int                CNT_W           = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]  ROW_LAST        = CNT_W'(SCAN_DIV - 1);
    localparam int                DB_W            = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DB_W-1:0]   DB_TARGET       = DB_W'(DEBOUNCE_SCANS);
    localparam logic [DB_W-1:0]   DB_ONE          = DB_W'(1);
    localparam bit                ACCEPT_ON_FIRST = (DEBOUNCE_SCANS == 1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    logic [3:0]       r_colMeta;
    logic [3:0]       r_colSync;
    logic [CNT_W-1:0] r_rowCnt;
    logic [1:0]       r_rowIdx;
    logic [15:0]      r_frameAcc;
    logic             r_frameDone;

    state_t           r_state;
    logic [3:0]       r_cand;
    logic [DB_W-1:0]  r_cnt;
    logic [3:0]       r_keyCode;
    logic             r_keyValid;
    logic             r_keyHeld;
    logic             r_multiKey;

    logic [4:0]       w_keyCount;
    logic [3:0]       w_frameCode;
    logic             w_isNone;
    logic             w_isOne;
    logic             w_isMulti;

    state_t           w_nextState;
    logic [3:0]       w_nextCand;
    logic [DB_W-1:0]  w_nextCnt;
    logic [3:0]       w_nextKeyCode;
    logic             w_nextKeyValid;
    logic             w_nextKeyHeld;
    logic             w_nextMultiKey;

    // Two-flop synchronizer; idles at "all released" so reset cannot fake a press
    always_ff @(posedge Clk100MHz) begin
        if (Rst) begin
            r_colMeta <= 4'hF;
            r_colSync <= 4'hF;
        end else begin
            r_colMeta <= Col;
            r_colSync <= r_colMeta;
        end
    end

    // Row timer: sample the settled row at the end of its period, then step to the next row
    always_ff @(posedge Clk100MHz) begin
        if (Rst) begin
            r_rowCnt    <= '0;
            r_rowIdx    <= 2'd0;
            r_frameAcc  <= 16'h0000;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            if (r_rowCnt == ROW_LAST) begin
                r_rowCnt                           <= '0;
                r_frameAcc[{r_rowIdx, 2'b00} +: 4] <= ~r_colSync;
                r_rowIdx                           <= r_rowIdx + 2'd1;
                r_frameDone                        <= (r_rowIdx == 2'd3);
            end else begin
                r_rowCnt <= r_rowCnt + 1'b1;
            end
        end
    end

    assign Row = ~(4'b0001 << r_rowIdx);

    // Classify the completed frame by how many keys it saw; the code is the bit index
    always_comb begin
        w_keyCount  = 5'd0;
        w_frameCode = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (r_frameAcc[i]) begin
                w_keyCount  = w_keyCount + 5'd1;
                w_frameCode = 4'(i);
            end
        end
        w_isNone  = (w_keyCount == 5'd0);
        w_isOne   = (w_keyCount == 5'd1);
        w_isMulti = (w_keyCount >= 5'd2);
    end

    // Debounce decisions are only taken on frame boundaries; strobe is a one-cycle default-low pulse
    always_comb begin
        w_nextState    = r_state;
        w_nextCand     = r_cand;
        w_nextCnt      = r_cnt;
        w_nextKeyCode  = r_keyCode;
        w_nextKeyValid = 1'b0;
        w_nextKeyHeld  = r_keyHeld;
        w_nextMultiKey = r_multiKey;
        if (r_frameDone) begin
            w_nextMultiKey = w_isMulti;
            case (r_state)
                IDLE: begin
                    if (w_isOne) begin
                        w_nextCand = w_frameCode;
                        if (ACCEPT_ON_FIRST) begin
                            w_nextState    = PRESSED;
                            w_nextKeyCode  = w_frameCode;
                            w_nextKeyValid = 1'b1;
                            w_nextKeyHeld  = 1'b1;
                            w_nextCnt      = '0;
                        end else begin
                            w_nextState = DEBOUNCE;
                            w_nextCnt   = DB_ONE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (w_isOne) begin
                        if (w_frameCode == r_cand) begin
                            if ((r_cnt + DB_ONE) >= DB_TARGET) begin
                                w_nextState    = PRESSED;
                                w_nextKeyCode  = r_cand;
                                w_nextKeyValid = 1'b1;
                                w_nextKeyHeld  = 1'b1;
                                w_nextCnt      = '0;
                            end else begin
                                w_nextCnt = r_cnt + DB_ONE;
                            end
                        end else begin
                            w_nextCand = w_frameCode;
                            w_nextCnt  = DB_ONE;
                        end
                    end else begin
                        w_nextState = IDLE;
                        w_nextCnt   = '0;
                    end
                end
                PRESSED: begin
                    if (w_isNone) begin
                        if (ACCEPT_ON_FIRST) begin
                            w_nextState   = IDLE;
                            w_nextKeyHeld = 1'b0;
                            w_nextCnt     = '0;
                        end else begin
                            w_nextState = RELEASE;
                            w_nextCnt   = DB_ONE;
                        end
                    end
                end
                RELEASE: begin
                    if (w_isNone) begin
                        if ((r_cnt + DB_ONE) >= DB_TARGET) begin
                            w_nextState   = IDLE;
                            w_nextKeyHeld = 1'b0;
                            w_nextCnt     = '0;
                        end else begin
                            w_nextCnt = r_cnt + DB_ONE;
                        end
                    end else begin
                        w_nextState = PRESSED;
                        w_nextCnt   = '0;
                    end
                end
                default: begin
                    w_nextState = IDLE;
                    w_nextCnt   = '0;
                end
            endcase
        end
    end

    // Debounce state and all user-facing outputs are registered together
    always_ff @(posedge Clk100MHz) begin
        if (Rst) begin
            r_state    <= IDLE;
            r_cand     <= 4'd0;
            r_cnt      <= '0;
            r_keyCode  <= 4'd0;
            r_keyValid <= 1'b0;
            r_keyHeld  <= 1'b0;
            r_multiKey <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_cand     <= w_nextCand;
            r_cnt      <= w_nextCnt;
            r_keyCode  <= w_nextKeyCode;
            r_keyValid <= w_nextKeyValid;
            r_keyHeld  <= w_nextKeyHeld;
            r_multiKey <= w_nextMultiKey;
        end
    end

    assign KeyCode  = r_keyCode;
    assign KeyValid = r_keyValid;
    assign KeyHeld  = r_keyHeld;
    assign MultiKey = r_multiKey;

endmodule
